// File: rtl/pipe_csa_addsub.sv
// Pipelined carry-select adder/subtractor: one BLK-bit carry-select block per stage, behind an operand register.
// Define PIPE_CSA_SAT_EN to saturate signed overflow in the final stage.
module pipe_csa_addsub #(
   parameter int WIDTH = 16,
   parameter int BLK   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mod,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             cout,
   output logic             ovf
);
   localparam int NBLK = WIDTH / BLK;

   if ((WIDTH % BLK) != 0 || BLK < 2) begin : g_param_check
      $error("pipe_csa_addsub: WIDTH must be a multiple of BLK and BLK must be at least 2");
   end

   // Offset of stage k's slice in the flat bx skew vector; slice k holds bits [(k+1)*BLK, WIDTH).
   function automatic int bx_off(input int k);
      int acc;
      acc = 0;
      for (int j = 0; j < k; j++) begin
         acc += WIDTH - (j + 1) * BLK;
      end
      return acc;
   endfunction

   localparam int BX_BITS = bx_off(NBLK - 1);
   localparam int BX_W    = (BX_BITS > 0) ? BX_BITS : 1;

   // Returns {carry_out, sum} of a BLK-bit ripple add.
   function automatic logic [BLK:0] ripple(input logic [BLK-1:0] x,
                                           input logic [BLK-1:0] z,
                                           input logic           c_in);
      logic [BLK:0] r;
      logic         c;
      c = c_in;
      r = '0;
      for (int i = 0; i < BLK; i++) begin
         r[i] = x[i] ^ z[i] ^ c;
         c    = (x[i] & z[i]) | (c & (x[i] ^ z[i]));
      end
      r[BLK] = c;
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] splice(input logic [WIDTH-1:0] w,
                                               input logic [BLK-1:0]   s,
                                               input int               lo);
      logic [WIDTH-1:0] r;
      r          = w;
      r[lo +: BLK] = s;
      return r;
   endfunction

   logic             adv;
   logic             op_valid_reg;
   logic [WIDTH-1:0] op_a_reg;
   logic [WIDTH-1:0] op_bx_reg;
   logic             op_mod_reg;
   logic [NBLK-1:0]  valid_reg;
   logic [NBLK-1:0]  carry_reg;
   logic [NBLK-1:0]  carry_next;
   logic [WIDTH-1:0] word_reg  [NBLK];
   logic [WIDTH-1:0] word_next [NBLK];
   logic [BX_W-1:0]  bx_skew_reg;
   logic [BX_W-1:0]  bx_skew_next;
   logic             ovf_reg;
   logic             ovf_next;

   // The whole pipeline moves as one unit; bubbles are not squeezed out.
   assign adv       = !out_valid || out_ready;
   assign in_ready  = adv;
   assign out_valid = valid_reg[NBLK-1];
   assign y         = word_reg[NBLK-1];
   assign cout      = carry_reg[NBLK-1];
   assign ovf       = ovf_reg;

   if (BX_BITS == 0) begin : g_no_skew
      assign bx_skew_next = '0;
   end

   genvar gi;
   for (gi = 0; gi < NBLK; gi++) begin : g_stage
      localparam int LO  = gi * BLK;
      localparam int REM = WIDTH - LO - BLK;

      // word_src: completed sum bits below LO, untouched A bits from LO upward.
      logic [WIDTH-1:0] word_src;
      logic [BLK-1:0]   bx_blk;
      logic             cin;
      logic [BLK:0]     sum0;
      logic [BLK:0]     sum1;
      logic [BLK:0]     sel;

      if (gi == 0) begin : g_src
         assign word_src = op_a_reg;
         assign bx_blk   = op_bx_reg[BLK-1:0];
         assign cin      = op_mod_reg;
      end else begin : g_src
         assign word_src = word_reg[gi-1];
         assign bx_blk   = bx_skew_reg[bx_off(gi-1) +: BLK];
         assign cin      = carry_reg[gi-1];
      end

      assign sum0           = ripple(word_src[LO +: BLK], bx_blk, 1'b0);
      assign sum1           = ripple(word_src[LO +: BLK], bx_blk, 1'b1);
      assign sel            = cin ? sum1 : sum0;
      assign carry_next[gi] = sel[BLK];

      if (REM > 0) begin : g_skew
         if (gi == 0) begin : g_first
            assign bx_skew_next[bx_off(0) +: REM] = op_bx_reg[WIDTH-1:BLK];
         end else begin : g_rest
            assign bx_skew_next[bx_off(gi) +: REM] = bx_skew_reg[bx_off(gi-1) + BLK +: REM];
         end
      end

      if (gi == NBLK - 1) begin : g_final
         logic             msb_cin;
         logic [WIDTH-1:0] raw;
         // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
         assign msb_cin  = sel[BLK-1] ^ word_src[WIDTH-1] ^ bx_blk[BLK-1];
         assign raw      = splice(word_src, sel[BLK-1:0], LO);
         assign ovf_next = msb_cin ^ sel[BLK];
`ifdef PIPE_CSA_SAT_EN
         assign word_next[gi] = ovf_next ? {~raw[WIDTH-1], {(WIDTH-1){raw[WIDTH-1]}}} : raw;
`else
         assign word_next[gi] = raw;
`endif
      end else begin : g_mid
         assign word_next[gi] = splice(word_src, sel[BLK-1:0], LO);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_valid_reg <= 1'b0;
         op_a_reg     <= '0;
         op_bx_reg    <= '0;
         op_mod_reg   <= 1'b0;
         valid_reg    <= '0;
         carry_reg    <= '0;
         bx_skew_reg  <= '0;
         ovf_reg      <= 1'b0;
         for (int k = 0; k < NBLK; k++) begin
            word_reg[k] <= '0;
         end
      end else if (adv) begin
         op_valid_reg <= in_valid;
         op_a_reg     <= a;
         op_bx_reg    <= b ^ {WIDTH{mod}};
         op_mod_reg   <= mod;
         valid_reg[0] <= op_valid_reg;
         for (int k = 1; k < NBLK; k++) begin
            valid_reg[k] <= valid_reg[k-1];
         end
         carry_reg   <= carry_next;
         bx_skew_reg <= bx_skew_next;
         ovf_reg     <= ovf_next;
         for (int k = 0; k < NBLK; k++) begin
            word_reg[k] <= word_next[k];
         end
      end
   end

endmodule

// File: tb/tb_pipe_csa_addsub.sv
// Directed bench for pipe_csa_addsub (WIDTH 16, BLK 4): latency, streaming, stall and mid-stream reset.
module tb_pipe_csa_addsub;
   localparam int NBLK = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = 16'h0;
   logic [15:0] b = 16'h0;
   logic        mod = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] y;
   logic        cout;
   logic        ovf;

   always #5 clk = ~clk;

   pipe_csa_addsub #(.WIDTH(16), .BLK(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .mod       (mod),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .cout      (cout),
      .ovf       (ovf)
   );

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        md;
      logic [15:0] yw;   // wrapped result
      logic [15:0] ys;   // saturated result
      logic        c;
      logic        o;
   } vec_t;

   vec_t vecs [12];
   vec_t exp_q [$];
   int   acc_q [$];

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;
   int n_results = 0;
   int last_out_cyc = 0;
   bit check_lat = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      tests_run++;
      if (got !== expv) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
      end
   endtask

   function automatic logic [15:0] exp_y(input vec_t v);
`ifdef PIPE_CSA_SAT_EN
      return v.ys;
`else
      return v.yw;
`endif
   endfunction

   // Result monitor: samples 1 time unit before the rising edge.
   always begin : mon
      vec_t e;
      int   ac;
      @(negedge clk);
      #4;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'(y), 32'hFFFF_FFFF);
         end else begin
            e  = exp_q.pop_front();
            ac = acc_q.pop_front();
            check("y", 32'(y), 32'(exp_y(e)));
            check("cout", 32'(cout), 32'(e.c));
            check("ovf", 32'(ovf), 32'(e.o));
            if (check_lat) check("latency", cyc - ac, NBLK);
            n_results++;
            last_out_cyc = cyc;
            $display("[TB] a=%h b=%h mod=%b -> y=%h cout=%b ovf=%b", e.a, e.b, e.md, y, cout, ovf);
         end
      end
   end

   // Presents one vector, holding it until accepted; returns at the following falling edge.
   task automatic send(input int idx);
      int guard;
      guard = 0;
      a = vecs[idx].a;
      b = vecs[idx].b;
      mod = vecs[idx].md;
      in_valid = 1'b1;
      forever begin
         #3;
         if (in_ready) break;
         guard++;
         if (guard > 50) begin
            check("send_timeout", 32'(in_ready), 32'd1);
            return;
         end
         @(negedge clk);
      end
      exp_q.push_back(vecs[idx]);
      acc_q.push_back(cyc + 1);
      @(negedge clk);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0) begin
         @(negedge clk);
         guard++;
         if (guard > 100) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
            acc_q.delete();
            return;
         end
      end
      @(negedge clk);
   endtask

   task automatic stall_seq();
      int          guard;
      logic [15:0] held;
      guard = 0;
      forever begin
         #3;
         if (out_valid) break;
         guard++;
         if (guard > 50) begin
            check("stall_wait", 32'(out_valid), 32'd1);
            return;
         end
         @(negedge clk);
      end
      @(negedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      held = y;
      for (int k = 0; k < 3; k++) begin
         #3;
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_out_valid", 32'(out_valid), 32'd1);
         check("stall_y_held", 32'(y), 32'(held));
         @(negedge clk);
      end
      out_ready = 1'b1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int base;
      int first_acc;
      //                a         b      md  y wrapped  y saturated c     o
      vecs[0]  = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 16'h1000, 1'b0, 1'b0};
      vecs[1]  = '{16'hC444, 16'hCB52, 1'b0, 16'h8F96, 16'h8F96, 1'b1, 1'b0};
      vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
      vecs[3]  = '{16'hFFFE, 16'hFFFF, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
      vecs[4]  = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 16'h2345, 1'b0, 1'b0};
      vecs[5]  = '{16'h0005, 16'h0003, 1'b1, 16'h0002, 16'h0002, 1'b1, 1'b0};
      vecs[6]  = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
      vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 16'hFFFE, 1'b1, 1'b0};
      vecs[8]  = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0};
      vecs[9]  = '{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
      vecs[10] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1};
      vecs[11] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 16'h7FFF, 1'b0, 1'b1};

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_y", 32'(y), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      rst = 1'b0;
      #3;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      // Single operation: carry ripples across every block boundary
      base = n_results;
      send(0);
      in_valid = 1'b0;
      drain();
      check("single_count", n_results - base, 1);

      // Eight back-to-back operations
      base = n_results;
      first_acc = cyc + 1;
      for (int i = 1; i <= 8; i++) send(i);
      in_valid = 1'b0;
      drain();
      check("b2b_count", n_results - base, 8);
      check("b2b_span", last_out_cyc - first_acc, 7 + NBLK);

      // Stream with a 3-cycle downstream stall
      check_lat = 1'b0;
      base = n_results;
      fork
         begin
            for (int i = 0; i < 12; i++) send(i);
            in_valid = 1'b0;
         end
         stall_seq();
      join
      drain();
      check("stall_count", n_results - base, 12);
      check_lat = 1'b1;

      // Reset with three operations in flight
      send(9);
      send(10);
      send(11);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      acc_q.delete();
      #3;
      check("midrst_y", 32'(y), 32'd0);
      check("midrst_valid_0", 32'(out_valid), 32'd0);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         #3;
         check("midrst_valid", 32'(out_valid), 32'd0);
      end
      @(negedge clk);
      base = n_results;
      send(11);
      in_valid = 1'b0;
      drain();
      check("post_rst_count", n_results - base, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pipe_csa_addsub.md
# pipe_csa_addsub

Parametrised, pipelined carry-select adder/subtractor. It is the next generation of the team's 16-bit combinational carry-select adder. Operands are split into `WIDTH/BLK` carry-select blocks, and each block is registered as its own pipeline stage. Operands and results are passed through skew and de-skew registers. A valid/ready handshake sustains one operation per cycle with back-pressure. It sits in the datapath wherever a wide add/subtract would otherwise limit the clock rate.

## Interface
Parameters:
- `WIDTH`, 16: operand and result width. Must be a multiple of `BLK`.
- `BLK`, 4: bits per carry-select block. Must be at least 2. `NBLK = WIDTH/BLK` = pipeline depth.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand set presented.
- `in_ready`  out  1  block accepts operands this cycle.
- `a`  in  WIDTH  operand A, two's complement or unsigned.
- `b`  in  WIDTH  operand B.
- `mod`  in  1  0 = A+B, 1 = A−B. Sampled with the operands.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `y`  out  WIDTH  result.
- `cout`  out  1  carry out of the MSB. For subtraction, 1 means no borrow.
- `ovf`  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Operand preparation: `bx = b ^ {WIDTH{mod}}`. Carry-in to block 0 is `mod`.
- Stage k (k = 0..NBLK−1) computes block k on bits `[k*BLK +: BLK]`:
  - two BLK-bit ripple sums, one with carry-in 0 and one with carry-in 1;
  - a mux selects between them using the carry registered by stage k−1 (stage 0 uses `mod`);
  - the selected sum and carry-out are registered.
- Skew: bits of `a`/`bx` for block k are delayed k cycles so they meet their incoming carry. Completed sum slices are carried forward (de-skew) so all of `y` is presented together.
- The last stage also registers the carry into the MSB, to form `ovf`.
- Arithmetic: `y = (a + bx + mod) mod 2^WIDTH`. `cout` is bit WIDTH of that sum.
- Every stage has a valid bit. Bubbles are not collapsed: the pipeline advances as a single unit.
- Global advance: `adv = !out_valid || out_ready`, and `in_ready = adv`.
  - When `adv = 1`, every stage register loads from its predecessor.
  - Stage-0 valid loads `in_valid`.
  - When `adv = 0`, all registers hold.
- Elaboration: if `WIDTH % BLK != 0` or `BLK < 2`, the block fails elaboration with `$error`.

## Timing
- Reset (`rst` high at an edge) clears:
  - all stage valids, so `out_valid = 0`;
  - `y = 0`, `cout = 0`, `ovf = 0`, and all carry and skew registers.
- `in_ready` is 1 in the cycle after reset.
- Latency: an operation accepted at edge N (`in_valid && in_ready`) appears with `out_valid = 1` after edge N+NBLK. With defaults, that is 4 cycles.
- Throughput: one operation per cycle while `out_ready` stays high.
- Stall: with `out_valid && !out_ready`, the outputs are stable and `in_ready = 0`. Any `in_valid` in that cycle is not accepted. The pipeline resumes on the cycle `out_ready` rises. No data is lost or duplicated.
- `in_ready` is combinational from `out_valid` and `out_ready`. There is no combinational path from `in_valid` to `out_valid`.
- `y`, `cout` and `ovf` are don't-care while `out_valid = 0`, but are never X after reset.
- Reset mid-operation: all in-flight operations are discarded. No partial result is ever presented.

## Configuration
- `PIPE_CSA_SAT_EN` defined: signed saturation is applied at the final stage.
  - On overflow, `y = {~s[WIDTH-1], {WIDTH-1{s[WIDTH-1]}}}`, where `s` is the raw sum. Positive overflow gives `0x7FFF` and negative overflow gives `0x8000` for WIDTH 16.
  - `ovf` still reports the overflow. `cout` is unaffected.
- Not defined: `y` is the raw wrapped sum. There is no saturation logic.

## Test plan
Defaults are WIDTH 16 and BLK 4, with `PIPE_CSA_SAT_EN` undefined unless stated.
- Carry across every block boundary: `a=0x0FFF`, `b=0x0001`, `mod=0` → 4 cycles later `y=0x1000`, `cout=0`, `ovf=0`.
- Unsigned carry-out and signed overflow:
  - `a=0xC444`, `b=0xCB52`, add → `y=0x8F96`, `cout=1`, `ovf=0`.
  - `a=0x7FFF`, `b=0x0001`, add → `y=0x8000`, `ovf=1`, `cout=0`.
- Subtraction with borrow: `a=0xFFFE`, `b=0xFFFF`, `mod=1` → `y=0xFFFF`, `cout=0`, `ovf=0`.
- Back-to-back and stall:
  - 8 consecutive ops with `out_ready=1` → 8 results on consecutive cycles, in order.
  - `out_ready` low for 3 cycles mid-stream → `in_ready=0` for those 3 cycles, `y` held, and no result dropped or repeated.
- Reset mid-stream: assert `rst` for 1 cycle with 3 ops in flight → `out_valid=0` for the next 4 cycles. A fresh op then completes with correct latency.
- `PIPE_CSA_SAT_EN` defined:
  - `a=0x7FFF`, `b=0x0001`, add → `y=0x7FFF`, `ovf=1`.
  - `a=0x8000`, `b=0x0001`, sub → `y=0x8000`, `ovf=1`.
